temporal_buffer_reader: RTL and testbench

TEMPORAL_BUFFER_READER -- requirements
Module: temporal_buffer_reader

---
 rtl/temporal_buffer_reader.sv | 132 +++++++++++++
 tb/tb_temporal_buffer_reader.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/temporal_buffer_reader.sv
// Streams the non-empty literals of one temporal-buffer candidate, chosen by the
// heuristic selector, to a downstream consumer one literal per handshake.
module temporal_buffer_reader #(
    parameter int NSAT                  = 3,
    parameter int LITERAL_ADDRESS_WIDTH = 12,
    parameter int MAX_CLAUSE_MEMBERSHIP = 20,
    localparam int LAW = LITERAL_ADDRESS_WIDTH,
    localparam int NL  = (NSAT - 1) * MAX_CLAUSE_MEMBERSHIP,
    localparam int IW  = (NSAT > 1) ? $clog2(NSAT) : 1
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              sel_valid_i,
    input  logic [IW-1:0]     sel_index_i,
    output logic              sel_ready_o,
    output logic [IW-1:0]     rd_index_o,
    input  logic [NL*LAW-1:0] literals_mi,
    output logic              lit_valid_o,
    output logic [LAW-1:0]    lit_o,
    output logic              lit_last_o,
    input  logic              lit_ready_i,
    output logic              done_o,
    output logic              err_o,
    output logic [1:0]        state_o
);

    localparam int PW = (NL > 1) ? $clog2(NL) : 1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        FETCH  = 2'd1,
        STREAM = 2'd2,
        DONE   = 2'd3
    } state_t;

    state_t         state;
    state_t         state_nxt;
    logic [LAW-1:0] shadow [NL];
    logic [PW-1:0]  ptr;
    logic           err_q;
    logic           sel_fire;
    logic           sel_in_range;
    logic           advance;
    logic           any_above;
    logic [LAW-1:0] cur_lit;

    // Both handshakes: a transfer happens on a rising edge where valid and ready
    // are both high; the sender holds its payload stable until that edge.
    assign sel_fire     = (state == IDLE) && sel_valid_i;
    assign sel_in_range = (32'(sel_index_i) < NSAT);
    assign cur_lit      = shadow[ptr];
    assign err_o        = err_q;
    assign state_o      = state;

    always_comb begin
        state_nxt   = state;
        sel_ready_o = 1'b0;
        lit_valid_o = 1'b0;
        lit_o       = '0;
        lit_last_o  = 1'b0;
        done_o      = 1'b0;
        advance     = 1'b0;
        any_above   = 1'b0;
        for (int k = 0; k < NL; k++) begin
            if ((k > int'(ptr)) && (shadow[k] != '0)) begin
                any_above = 1'b1;
            end
        end
        case (state)
            IDLE: begin
                sel_ready_o = 1'b1;
                if (sel_valid_i && sel_in_range) begin
                    state_nxt = FETCH;
                end
            end
            FETCH: begin
                state_nxt = STREAM;
            end
            STREAM: begin
                lit_o       = cur_lit;
                lit_valid_o = (cur_lit != '0);
                lit_last_o  = lit_valid_o && !any_above;
                // Empty slots are skipped in one cycle without a downstream beat.
                advance     = !lit_valid_o || lit_ready_i;
                if (advance && (ptr == PW'(NL - 1))) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                done_o    = 1'b1;
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            ptr        <= '0;
            rd_index_o <= '0;
            err_q      <= 1'b0;
            for (int k = 0; k < NL; k++) begin
                shadow[k] <= '0;
            end
        end else begin
            err_q <= sel_fire && !sel_in_range;
            if (sel_fire && sel_in_range) begin
                rd_index_o <= sel_index_i;
            end
            // The snapshot decouples streaming from later buffer rewrites.
            if (state == FETCH) begin
                for (int k = 0; k < NL; k++) begin
                    shadow[k] <= literals_mi[k*LAW +: LAW];
                end
                ptr <= '0;
            end else if ((state == STREAM) && advance && (ptr != PW'(NL - 1))) begin
                ptr <= ptr + PW'(1);
            end
        end
    end

endmodule

// File: tb/tb_temporal_buffer_reader.sv
// Directed bench for temporal_buffer_reader: streaming, backpressure, empty and
// invalid selections, mid-stream reset and buffer rewrite after capture.
module tb_temporal_buffer_reader;

    localparam int NSAT = 3;
    localparam int LAW  = 12;
    localparam int MC   = 20;
    localparam int NL   = (NSAT - 1) * MC;
    localparam int IW   = $clog2(NSAT);

    logic              clk = 1'b0;
    logic              rst_n;
    logic              sel_valid;
    logic [IW-1:0]     sel_index;
    logic              sel_ready;
    logic [IW-1:0]     rd_index;
    logic [NL*LAW-1:0] literals;
    logic              lit_valid;
    logic [LAW-1:0]    lit;
    logic              lit_last;
    logic              lit_ready;
    logic              done;
    logic              err;
    logic [1:0]        state_dbg;

    logic [LAW-1:0]    exp_q[$];
    int                checks = 0;
    int                errors = 0;

    temporal_buffer_reader #(
        .NSAT                  (NSAT),
        .LITERAL_ADDRESS_WIDTH (LAW),
        .MAX_CLAUSE_MEMBERSHIP (MC)
    ) dut (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .sel_valid_i (sel_valid),
        .sel_index_i (sel_index),
        .sel_ready_o (sel_ready),
        .rd_index_o  (rd_index),
        .literals_mi (literals),
        .lit_valid_o (lit_valid),
        .lit_o       (lit),
        .lit_last_o  (lit_last),
        .lit_ready_i (lit_ready),
        .done_o      (done),
        .err_o       (err),
        .state_o     (state_dbg)
    );

    // clock / reset
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // driver tasks
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_basic();
        literals = '0;
        literals[0*LAW +: LAW]  = 12'h012;
        literals[5*LAW +: LAW]  = 12'h345;
        literals[39*LAW +: LAW] = 12'hFFF;
    endtask

    task automatic push_basic();
        exp_q.push_back(12'h012);
        exp_q.push_back(12'h345);
        exp_q.push_back(12'hFFF);
    endtask

    task automatic select(input logic [IW-1:0] idx);
        sel_valid = 1'b1;
        sel_index = idx;
        tick();
        sel_valid = 1'b0;
        sel_index = '0;
    endtask

    task automatic check_reset(input string tag);
        chk({tag, "_lit_valid"}, 32'(lit_valid), 0);
        chk({tag, "_lit_last"},  32'(lit_last), 0);
        chk({tag, "_done"},      32'(done), 0);
        chk({tag, "_err"},       32'(err), 0);
        chk({tag, "_lit"},       32'(lit), 0);
        chk({tag, "_sel_ready"}, 32'(sel_ready), 1);
        chk({tag, "_rd_index"},  32'(rd_index), 0);
        chk({tag, "_state"},     32'(state_dbg), 0);
    endtask

    // Scoreboard loop: called right after the handshake edge; n counts edges since it.
    task automatic run_stream(input string tag, input int stall_n, input bit rewrite,
                              input int exp_done, input int exp_first);
        int n = 0;
        int stall = 0;
        int first_n = -1;
        bit done_seen = 1'b0;
        lit_ready = 1'b1;
        while (!done_seen && n < 100) begin
            tick();
            n++;
            if (rewrite && n == 1) begin
                literals = {NL{12'hABC}};
            end
            if (done) begin
                done_seen = 1'b1;
                chk({tag, "_done_cycle"}, 32'(n), 32'(exp_done));
                chk({tag, "_beats_left"}, 32'(exp_q.size()), 0);
            end else if (lit_valid) begin
                if (first_n < 0) first_n = n;
                if (exp_q.size() == 0) begin
                    chk({tag, "_unexpected_beat"}, 32'(lit_valid), 0);
                end else begin
                    chk({tag, "_lit"}, 32'(lit), 32'(exp_q[0]));
                    chk({tag, "_last"}, 32'(lit_last), 32'(exp_q.size() == 1));
                    if (exp_q[0] == 12'h345 && stall < stall_n) begin
                        lit_ready = 1'b0;
                        stall++;
                    end else begin
                        lit_ready = 1'b1;
                        void'(exp_q.pop_front());
                    end
                end
            end else begin
                chk({tag, "_last_no_valid"}, 32'(lit_last), 0);
            end
        end
        lit_ready = 1'b1;
        chk({tag, "_done_seen"}, 32'(done_seen), 1);
        chk({tag, "_first_valid"}, 32'(first_n), 32'(exp_first));
        tick();
        chk({tag, "_done_pulse_end"}, 32'(done), 0);
        chk({tag, "_idle_ready"}, 32'(sel_ready), 1);
    endtask

    initial begin
        rst_n     = 1'b0;
        sel_valid = 1'b0;
        sel_index = '0;
        lit_ready = 1'b1;
        literals  = '0;
        #3;
        check_reset("init");
        tick();
        tick();
        rst_n = 1'b1;

        // basic streaming from index 1
        set_basic();
        push_basic();
        select(1);
        chk("basic_rd_index", 32'(rd_index), 1);
        chk("basic_fetch_state", 32'(state_dbg), 1);
        chk("basic_sel_ready_busy", 32'(sel_ready), 0);
        run_stream("basic", 0, 1'b0, 41, 1);

        // backpressure: four stalled cycles on 0x345
        set_basic();
        push_basic();
        select(2);
        chk("bp_rd_index", 32'(rd_index), 2);
        run_stream("bp", 4, 1'b0, 45, 1);

        // out-of-range index
        sel_valid = 1'b1;
        sel_index = 2'd3;
        tick();
        sel_valid = 1'b0;
        sel_index = '0;
        chk("inv_err", 32'(err), 1);
        chk("inv_state", 32'(state_dbg), 0);
        chk("inv_sel_ready", 32'(sel_ready), 1);
        chk("inv_rd_index", 32'(rd_index), 2);
        tick();
        chk("inv_err_pulse_end", 32'(err), 0);
        chk("inv_no_fetch", 32'(state_dbg), 0);

        // all-empty selection
        literals = '0;
        select(0);
        chk("empty_rd_index", 32'(rd_index), 0);
        run_stream("empty", 0, 1'b0, 41, -1);

        // buffer rewritten after capture
        set_basic();
        push_basic();
        select(1);
        run_stream("rewrite", 0, 1'b1, 41, 1);

        // reset after the second beat
        set_basic();
        lit_ready = 1'b1;
        select(1);
        repeat (7) tick();
        #2;
        rst_n = 1'b0;
        #1;
        check_reset("mid_rst");
        @(posedge clk);
        #1;
        chk("mid_rst_no_done", 32'(done), 0);
        rst_n     = 1'b1;
        sel_valid = 1'b1;
        sel_index = 2'd1;
        tick();
        sel_valid = 1'b0;
        sel_index = '0;
        chk("post_rst_fetch", 32'(state_dbg), 1);
        chk("post_rst_rd_index", 32'(rd_index), 1);
        push_basic();
        run_stream("post_rst", 0, 1'b0, 41, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
